// File: rtl/shared_port_arbiter_if.sv
// Bundles the two requesters, the shared memory port and the per-requester
// grant/done/err feedback into a single connection.
interface shared_port_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic [WIDTH-1:0] addr0;
    logic             req1;
    logic [WIDTH-1:0] addr1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic             err;
    logic             mem_valid;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_ready;

    // Requesters and memory model side.
    modport master (
        output req0, addr0, req1, addr1, mem_ready,
        input  gnt0, gnt1, done0, done1, err, mem_valid, mem_addr
    );

    // Arbiter side.
    modport slave (
        input  req0, addr0, req1, addr1, mem_ready,
        output gnt0, gnt1, done0, done1, err, mem_valid, mem_addr
    );
endinterface

// File: rtl/shared_port_arbiter.sv
// Two-requester arbiter for the shared sail-core memory port
// (req0 = instruction fetch, req1 = data access), with a watchdog that
// aborts any transaction the memory never acknowledges.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | port free; requests sampled and arbitrated on the next edge
// OWN   | port granted to requester sel; waiting for mem_ready/timeout

module mux2to1 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? a1 : a0;
endmodule

module shared_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int FAIR    = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_port_arbiter_if.slave bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    // The watchdog fires on the edge where the counter already shows
    // TIMEOUT-1, so the owner gets exactly TIMEOUT cycles in OWN.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       sel;
    logic       last_owner;
    logic [7:0] wd_cnt;
    logic       gnt0_q;
    logic       gnt1_q;
    logic       done0_q;
    logic       done1_q;
    logic       err_q;
    logic       mem_valid_q;
    logic       win;
    logic [WIDTH-1:0] mux_y;

    // Arbitration winner for the current IDLE cycle.
    always_comb begin
        win = 1'b0;
        if (bus.req1 && !bus.req0) begin
            win = 1'b1;
        end else if (bus.req1 && bus.req0 && (FAIR != 0)) begin
            win = !last_owner;
        end
    end

    // Arbiter FSM with registered grant/done/err/valid outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            sel         <= 1'b0;
            last_owner  <= 1'b1;
            wd_cnt      <= 8'd0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state       <= S_OWN;
                        sel         <= win;
                        gnt0_q      <= !win;
                        gnt1_q      <= win;
                        mem_valid_q <= 1'b1;
                        wd_cnt      <= 8'd0;
                    end
                end
                S_OWN: begin
                    if (bus.mem_ready || (wd_cnt == WD_LAST)) begin
                        // mem_ready takes precedence over a coincident timeout.
                        done0_q     <= bus.mem_ready && !sel;
                        done1_q     <= bus.mem_ready && sel;
                        err_q       <= !bus.mem_ready;
                        state       <= S_IDLE;
                        last_owner  <= sel;
                        wd_cnt      <= 8'd0;
                        gnt0_q      <= 1'b0;
                        gnt1_q      <= 1'b0;
                        mem_valid_q <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    mux2to1 #(
        .WIDTH(WIDTH)
    ) u_addr_mux (
        .sel(sel),
        .a0 (bus.addr0),
        .a1 (bus.addr1),
        .y  (mux_y)
    );

    assign bus.mem_addr  = mux_y;
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.err       = err_q;
    assign bus.mem_valid = mem_valid_q;
endmodule
